// File: rtl/cpc_pi_pkg.sv
// cpc_pi_pkg: shared port offsets, register bit positions and Pi handshake states
package cpc_pi_pkg;
  localparam logic [15:0] DATA_OFS = 16'd0;
  localparam logic [15:0] CTRL_OFS = 16'd1;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL = 3;
  localparam int ST_INT_ENA = 4;
  localparam int ST_TX_OVF = 7;
  localparam int CT_INT_ENA = 0;
  localparam int CT_TX_FLUSH = 6;
  localparam int CT_OVF_CLR = 7;
  typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_WAIT, S_ACK} pi_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead single-clock FIFO with push, pop, flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count[DEPTH_LOG2];
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst_b || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
endmodule

// File: rtl/cpc_pi_mailbox.sv
// cpc_pi_mailbox: buffered byte mailbox between the CPC Z80 I/O bus and a Pi REQ/ACK port
module cpc_pi_mailbox
  import cpc_pi_pkg::*;
#(
  parameter logic [15:0] IO_BASE = 16'hFD80,
  parameter int DEPTH_LOG2 = 4,
  parameter bit INT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_doe,
  input  logic        iorq_b,
  input  logic        rd_b,
  input  logic        wr_b,
  input  logic        m1_b,
  output logic        int_oe,
  input  logic [7:0]  pi_din,
  output logic [7:0]  pi_dout,
  output logic        pi_doe,
  input  logic        pi_req,
  input  logic        pi_dir,
  output logic        pi_ack
);
  pi_state_t state, state_n;
  logic io_cyc, sel_data, sel_ctrl, rd_data, rd_any, wr_any, wr_rise;
  logic wr_q, rd_q, rd_ne, tx_ovf, int_ena;
  logic tx_push, tx_pop_pi, tx_flush, rx_push_pi, rx_pop_cpu, ctrl_wr, load;
  logic tx_full, tx_empty, rx_full, rx_empty, rx_avail;
  logic [7:0] tx_head, rx_head, status;
  logic [DEPTH_LOG2:0] tx_cnt, rx_cnt;
  logic req_m, req_s, dir_m, dir_s, dir_l;
  logic [1:0] vld;
  assign io_cyc = !iorq_b & m1_b;
  assign sel_data = io_cyc & (cpu_addr == IO_BASE + DATA_OFS);
  assign sel_ctrl = io_cyc & (cpu_addr == IO_BASE + CTRL_OFS);
  assign rd_data = sel_data & !rd_b;
  assign rd_any = (sel_data | sel_ctrl) & !rd_b;
  assign wr_any = (sel_data | sel_ctrl) & !wr_b;
  assign wr_rise = wr_any & !wr_q;
  assign tx_push = wr_rise & sel_data;
  assign ctrl_wr = wr_rise & sel_ctrl;
  assign tx_flush = ctrl_wr & cpu_din[CT_TX_FLUSH];
  assign rx_pop_cpu = rd_q & !rd_data & rd_ne;
  assign rx_avail = |rx_cnt;
  assign int_oe = INT_EN & int_ena & rx_avail;
  assign cpu_doe = RESET_B & rd_any;
  assign cpu_dout = !cpu_doe ? 8'hFF : rd_data ? (rx_empty ? 8'hFF : rx_head) : status;
  assign pi_ack = state == S_ACK;
  always_comb begin
    status = '0;
    status[ST_TX_OVF] = tx_ovf;
    status[ST_INT_ENA] = int_ena;
    status[ST_RX_FULL] = rx_cnt[DEPTH_LOG2];
    status[ST_TX_EMPTY] = tx_cnt == '0;
    status[ST_TX_FULL] = tx_cnt[DEPTH_LOG2];
    status[ST_RX_AVAIL] = rx_avail;
  end
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) tx_fifo (
    .clk(CLK), .rst_b(RESET_B), .push(tx_push), .pop(tx_pop_pi), .flush(tx_flush),
    .din(cpu_din), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) rx_fifo (
    .clk(CLK), .rst_b(RESET_B), .push(rx_push_pi), .pop(rx_pop_cpu), .flush(1'b0),
    .din(pi_din), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );
  always_ff @(posedge CLK)
    if (!RESET_B) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      rd_ne <= 1'b0;
      tx_ovf <= 1'b0;
      int_ena <= 1'b0;
    end else begin
      wr_q <= wr_any;
      rd_q <= rd_data;
      rd_ne <= rd_data & !rx_empty;
      if (ctrl_wr) int_ena <= cpu_din[CT_INT_ENA];
      if (ctrl_wr && cpu_din[CT_OVF_CLR]) tx_ovf <= 1'b0;
      else if (tx_push && tx_full && !tx_pop_pi) tx_ovf <= 1'b1;
    end
  always_ff @(posedge CLK)
    if (!RESET_B) begin
      state <= S_DRAIN;
      vld <= '0;
      req_m <= 1'b0;
      req_s <= 1'b0;
      dir_m <= 1'b0;
      dir_s <= 1'b0;
      dir_l <= 1'b0;
      pi_dout <= '0;
      pi_doe <= 1'b0;
    end else begin
      state <= state_n;
      vld <= {vld[0], 1'b1};
      req_m <= pi_req;
      req_s <= req_m;
      dir_m <= pi_dir;
      dir_s <= dir_m;
      if (state == S_IDLE && req_s) dir_l <= dir_s;
      if (load) begin
        pi_dout <= tx_head;
        pi_doe <= 1'b1;
      end else if (state == S_ACK && !req_s) pi_doe <= 1'b0;
    end
  always_comb begin
    state_n = state;
    rx_push_pi = 1'b0;
    tx_pop_pi = 1'b0;
    load = 1'b0;
    case (state)
      S_DRAIN: if (vld[1] && !req_s) state_n = S_IDLE;
      S_IDLE: if (req_s) state_n = S_WAIT;
      S_WAIT:
        if (!req_s) state_n = S_IDLE;
        else if (!dir_l && !rx_full) begin
          rx_push_pi = 1'b1;
          state_n = S_ACK;
        end else if (dir_l && !tx_empty) begin
          load = 1'b1;
          state_n = S_ACK;
        end
      S_ACK:
        if (!req_s) begin
          tx_pop_pi = dir_l & !tx_empty;
          state_n = S_IDLE;
        end
      default: state_n = S_DRAIN;
    endcase
  end
endmodule

// File: tb/tb_cpc_pi_mailbox.sv
// tb_cpc_pi_mailbox: directed self-checking bench for the CPC/Pi mailbox
module tb_cpc_pi_mailbox;
  localparam logic [15:0] DATA = 16'hFD80;
  localparam logic [15:0] CTRL = 16'hFD81;
  logic CLK = 1'b0;
  logic RESET_B = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic [7:0] cpu_dout;
  logic cpu_doe;
  logic iorq_b = 1'b1;
  logic rd_b = 1'b1;
  logic wr_b = 1'b1;
  logic m1_b = 1'b1;
  logic int_oe;
  logic [7:0] pi_din = '0;
  logic [7:0] pi_dout;
  logic pi_doe;
  logic pi_req = 1'b0;
  logic pi_dir = 1'b0;
  logic pi_ack;
  int checks = 0;
  int errors = 0;
  cpc_pi_mailbox dut (
    .CLK(CLK), .RESET_B(RESET_B), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_doe(cpu_doe), .iorq_b(iorq_b), .rd_b(rd_b),
    .wr_b(wr_b), .m1_b(m1_b), .int_oe(int_oe), .pi_din(pi_din),
    .pi_dout(pi_dout), .pi_doe(pi_doe), .pi_req(pi_req), .pi_dir(pi_dir),
    .pi_ack(pi_ack)
  );
  always #5 CLK = ~CLK;
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_din = d;
    iorq_b = 1'b0;
    wr_b = 1'b0;
    cyc(2);
    iorq_b = 1'b1;
    wr_b = 1'b1;
    cyc(1);
  endtask
  task automatic io_rd(input logic [15:0] a, output logic [7:0] d, output logic oe);
    cpu_addr = a;
    iorq_b = 1'b0;
    rd_b = 1'b0;
    @(negedge CLK);
    d = cpu_dout;
    oe = cpu_doe;
    cyc(1);
    iorq_b = 1'b1;
    rd_b = 1'b1;
    cyc(2);
  endtask
  task automatic wait_ack(input logic lvl, input int lim, output int n);
    n = 0;
    while (pi_ack !== lvl && n < lim) begin
      cyc(1);
      n++;
    end
    if (pi_ack !== lvl) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout ack=%b wanted %b after %0d cycles", pi_ack, lvl, n);
    end
  endtask
  task automatic pi_read(output logic [7:0] d, output int n);
    int m;
    pi_dir = 1'b1;
    pi_req = 1'b1;
    wait_ack(1'b1, 100, n);
    d = pi_dout;
    pi_req = 1'b0;
    wait_ack(1'b0, 100, m);
    cyc(1);
  endtask
  task automatic pi_write(input logic [7:0] d);
    int m;
    pi_dir = 1'b0;
    pi_din = d;
    pi_req = 1'b1;
    wait_ack(1'b1, 100, m);
    pi_req = 1'b0;
    wait_ack(1'b0, 100, m);
    cyc(1);
  endtask
  task automatic test_reset;
    logic [7:0] d;
    logic oe;
    RESET_B = 1'b0;
    cyc(3);
    checks++; if (cpu_doe !== 1'b0) begin errors++; $display("FAIL rst_cpu_doe got %b exp 0", cpu_doe); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL rst_cpu_dout got %h exp ff", cpu_dout); end
    checks++; if (int_oe !== 1'b0) begin errors++; $display("FAIL rst_int_oe got %b exp 0", int_oe); end
    checks++; if (pi_doe !== 1'b0) begin errors++; $display("FAIL rst_pi_doe got %b exp 0", pi_doe); end
    checks++; if (pi_dout !== 8'h00) begin errors++; $display("FAIL rst_pi_dout got %h exp 00", pi_dout); end
    checks++; if (pi_ack !== 1'b0) begin errors++; $display("FAIL rst_pi_ack got %b exp 0", pi_ack); end
    RESET_B = 1'b1;
    cyc(4);
    io_rd(CTRL, d, oe);
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rst_status_oe got %b exp 1", oe); end
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL rst_status got %h exp 04", d); end
  endtask
  task automatic test_tx_to_pi;
    logic [7:0] d;
    logic oe;
    int n;
    io_wr(DATA, 8'hA5);
    io_wr(DATA, 8'h5A);
    pi_read(d, n);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL tx_first got %h exp a5", d); end
    checks++; if (n !== 4) begin errors++; $display("FAIL tx_ack_latency got %0d exp 4", n); end
    pi_read(d, n);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL tx_second got %h exp 5a", d); end
    checks++; if (pi_doe !== 1'b0) begin errors++; $display("FAIL tx_doe_release got %b exp 0", pi_doe); end
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL tx_drained_status got %h exp 04", d); end
  endtask
  task automatic test_pi_to_cpc;
    logic [7:0] d;
    logic oe;
    pi_write(8'h3C);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL rx_avail_status got %h exp 05", d); end
    io_rd(DATA, d, oe);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rx_data got %h exp 3c", d); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rx_data_oe got %b exp 1", oe); end
    io_rd(DATA, d, oe);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rx_empty_data got %h exp ff", d); end
    io_rd(CTRL, d, oe);
    checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL rx_avail_clear got %b exp 0", d[0]); end
  endtask
  task automatic test_overflow;
    logic [7:0] d;
    logic oe;
    for (int i = 0; i < 16; i++) io_wr(DATA, 8'(i));
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovf_full_status got %h exp 02", d); end
    io_wr(DATA, 8'hEE);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h82) begin errors++; $display("FAIL ovf_status got %h exp 82", d); end
    io_wr(CTRL, 8'h80);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovf_clear got %h exp 02", d); end
    io_wr(CTRL, 8'h40);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL tx_flush got %h exp 04", d); end
  endtask
  task automatic test_backpressure;
    logic [7:0] d;
    logic oe;
    int hits;
    int n;
    hits = 0;
    pi_dir = 1'b1;
    pi_req = 1'b1;
    repeat (50) begin
      cyc(1);
      if (pi_ack) hits++;
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL stall_ack got %0d ack cycles exp 0", hits); end
    cpu_addr = DATA;
    cpu_din = 8'h11;
    iorq_b = 1'b0;
    wr_b = 1'b0;
    wait_ack(1'b1, 3, n);
    checks++; if (pi_dout !== 8'h11) begin errors++; $display("FAIL stall_release_data got %h exp 11", pi_dout); end
    checks++; if (pi_doe !== 1'b1) begin errors++; $display("FAIL stall_release_doe got %b exp 1", pi_doe); end
    cyc(1);
    iorq_b = 1'b1;
    wr_b = 1'b1;
    cyc(1);
    pi_req = 1'b0;
    wait_ack(1'b0, 100, n);
    cyc(1);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL stall_popped got %h exp 04", d); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] d;
    logic oe;
    int hits;
    int n;
    hits = 0;
    pi_dir = 1'b0;
    pi_din = 8'h77;
    pi_req = 1'b1;
    wait_ack(1'b1, 100, n);
    RESET_B = 1'b0;
    cyc(1);
    RESET_B = 1'b1;
    checks++; if (pi_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b exp 0", pi_ack); end
    repeat (20) begin
      cyc(1);
      if (pi_ack) hits++;
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL midrst_held_req got %0d ack cycles exp 0", hits); end
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL midrst_no_push got %h exp 04", d); end
    pi_req = 1'b0;
    cyc(4);
    pi_req = 1'b1;
    wait_ack(1'b1, 100, n);
    pi_req = 1'b0;
    wait_ack(1'b0, 100, n);
    cyc(1);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL midrst_new_req got %h exp 05", d); end
    io_rd(DATA, d, oe);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL midrst_data got %h exp 77", d); end
  endtask
  task automatic test_interrupt;
    logic [7:0] d;
    logic oe;
    io_wr(CTRL, 8'h01);
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h14) begin errors++; $display("FAIL int_ena_status got %h exp 14", d); end
    checks++; if (int_oe !== 1'b0) begin errors++; $display("FAIL int_idle got %b exp 0", int_oe); end
    pi_write(8'h42);
    checks++; if (int_oe !== 1'b1) begin errors++; $display("FAIL int_raise got %b exp 1", int_oe); end
    io_rd(DATA, d, oe);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL int_data got %h exp 42", d); end
    checks++; if (int_oe !== 1'b0) begin errors++; $display("FAIL int_clear got %b exp 0", int_oe); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] d;
    logic oe;
    int n;
    io_wr(DATA, 8'hC1);
    io_wr(DATA, 8'hC2);
    io_wr(DATA, 8'hC3);
    pi_read(d, n);
    checks++; if (d !== 8'hC1) begin errors++; $display("FAIL b2b_0 got %h exp c1", d); end
    pi_read(d, n);
    checks++; if (d !== 8'hC2) begin errors++; $display("FAIL b2b_1 got %h exp c2", d); end
    pi_read(d, n);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL b2b_2 got %h exp c3", d); end
    io_rd(CTRL, d, oe);
    checks++; if (d !== 8'h14) begin errors++; $display("FAIL b2b_status got %h exp 14", d); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_tx_to_pi();
    test_pi_to_cpc();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_interrupt();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
